// File: rtl/mem_arbiter_pkg.sv
// Shared CPU-side definitions for the memory arbiter: state encoding,
// default bus widths and the grant-priority rule.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    // Data wins unless it also won last time and a fetch is waiting.
    function automatic logic pick_data(input logic dm_pend,
                                       input logic if_pend,
                                       input logic last_data);
        return dm_pend && !(last_data && if_pend);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port, shared memory port and status lines;
// slave is the arbiter's view, master is the cpu/memory side.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_re;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    logic              stall;
    logic              err;

    modport slave (
        input  if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata, mem_valid,
        output if_rdata, if_ready, dm_rdata, dm_ready,
               mem_re, mem_we, mem_addr, mem_wdata, stall, err
    );

    modport master (
        output if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata, mem_valid,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
               mem_re, mem_we, mem_addr, mem_wdata, stall, err
    );
endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// 4-bit busy-cycle counter; expired goes high once LIMIT cycles have elapsed
// since the last clear.
module wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [3:0] count;

    assign expired = (count == 4'(LIMIT));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 4'd1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one shared memory
// port, one access at a time, with a per-access timeout and a sticky error.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    state_t            state;
    logic              last_data;
    logic              dm_pend;
    logic              any_req;
    logic              busy;
    logic              expired;
    logic              done;
    logic              take_data;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    assign dm_pend = bus.dm_re || bus.dm_we;
    assign any_req = dm_pend || bus.if_req;
    assign busy    = (state != IDLE);
    assign done    = busy && (bus.mem_valid || expired);

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        take_data   = 1'b0;
        grant_addr  = bus.if_addr;
        grant_wdata = '0;
        if (pick_data(dm_pend, bus.if_req, last_data)) begin
            take_data   = 1'b1;
            grant_addr  = bus.dm_addr;
            grant_wdata = bus.dm_wdata;
        end
    end

    wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE && any_req),
        .enable  (busy),
        .expired (expired)
    );

    // Completion is reported in the cycle the memory answers (or times out).
    assign bus.if_ready = (state == FETCH) && done;
    assign bus.dm_ready = (state == DATA) && done;
    assign bus.if_rdata = (state == FETCH && bus.mem_valid) ? bus.mem_rdata : '0;
    assign bus.dm_rdata = (state == DATA && bus.mem_valid && !bus.mem_we) ? bus.mem_rdata : '0;
    assign bus.stall    = (bus.if_req && !bus.if_ready) || (dm_pend && !bus.dm_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_data     <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state         <= take_data ? DATA : FETCH;
                        last_data     <= take_data;
                        // A read+write collision is carried out as a write.
                        bus.mem_re    <= !take_data || !bus.dm_we;
                        bus.mem_we    <= take_data && bus.dm_we;
                        bus.mem_addr  <= grant_addr;
                        bus.mem_wdata <= grant_wdata;
                        if (take_data && bus.dm_re && bus.dm_we) begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                FETCH, DATA: begin
                    if (done) begin
                        state      <= IDLE;
                        bus.mem_re <= 1'b0;
                        bus.mem_we <= 1'b0;
                        if (!bus.mem_valid) begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, arbitration order, write, timeout,
// reset mid-access and read/write collision.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_re     = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst = 1'b1;
        step();
        #1;
        check({tag, "_rst_mem_re"}, bus.mem_re, 0);
        check({tag, "_rst_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_rst_err"}, bus.err, 0);
        check({tag, "_rst_stall"}, bus.stall, 0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        do_reset("r0");

        // Fetch only, memory answers two cycles after mem_re rises.
        bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        #1 check("f_stall_idle", bus.stall, 1);
        step(); #1;
        check("f_mem_re", bus.mem_re, 1);
        check("f_mem_addr", bus.mem_addr, 16'h0010);
        check("f_ready_b0", bus.if_ready, 0);
        step(); #1;
        check("f_stall_b1", bus.stall, 1);
        step();
        bus.mem_valid = 1'b1; bus.mem_rdata = 16'hA5A5;
        #1;
        check("f_if_ready", bus.if_ready, 1);
        check("f_if_rdata", bus.if_rdata, 16'hA5A5);
        check("f_stall_done", bus.stall, 0);
        step();
        bus.mem_valid = 1'b0; bus.if_req = 1'b0;
        #1;
        check("f_mem_re_drop", bus.mem_re, 0);
        check("f_if_ready_low", bus.if_ready, 0);

        // Contention from reset: data, then fetch, then data again.
        do_reset("r1");
        bus.if_req = 1'b1; bus.if_addr = 16'h0030;
        bus.dm_re  = 1'b1; bus.dm_addr = 16'h0020;
        step(); #1;
        check("a_first_addr", bus.mem_addr, 16'h0020);
        check("a_first_re", bus.mem_re, 1);
        step();
        bus.mem_valid = 1'b1; bus.mem_rdata = 16'hBEEF;
        #1;
        check("a_dm_ready", bus.dm_ready, 1);
        check("a_dm_rdata", bus.dm_rdata, 16'hBEEF);
        check("a_if_ready_no", bus.if_ready, 0);
        step();
        bus.mem_valid = 1'b0;
        #1 check("a_idle_re", bus.mem_re, 0);
        step(); #1;
        check("a_second_addr", bus.mem_addr, 16'h0030);
        step();
        bus.mem_valid = 1'b1; bus.mem_rdata = 16'h1111;
        #1;
        check("a_if_ready", bus.if_ready, 1);
        check("a_if_rdata", bus.if_rdata, 16'h1111);
        step();
        bus.mem_valid = 1'b0; bus.if_req = 1'b0;
        step(); #1;
        check("a_third_addr", bus.mem_addr, 16'h0020);
        step();
        bus.mem_valid = 1'b1; bus.mem_rdata = 16'h2222;
        #1 check("a_third_ready", bus.dm_ready, 1);
        step();
        idle_inputs();

        // Write: command held until the memory answers, read data forced to 0.
        bus.dm_we = 1'b1; bus.dm_addr = 16'h0042; bus.dm_wdata = 16'h1234;
        step(); #1;
        check("w_mem_we", bus.mem_we, 1);
        check("w_mem_re", bus.mem_re, 0);
        check("w_mem_addr", bus.mem_addr, 16'h0042);
        check("w_mem_wdata", bus.mem_wdata, 16'h1234);
        step(); #1;
        check("w_mem_we_hold", bus.mem_we, 1);
        check("w_wdata_hold", bus.mem_wdata, 16'h1234);
        step();
        bus.mem_valid = 1'b1; bus.mem_rdata = 16'hFFFF;
        #1;
        check("w_dm_ready", bus.dm_ready, 1);
        check("w_dm_rdata", bus.dm_rdata, 0);
        step();
        idle_inputs();
        #1;
        check("w_mem_we_drop", bus.mem_we, 0);
        check("w_err_clean", bus.err, 0);

        // Timeout: no memory answer; abort in busy cycle 15 with zero data.
        bus.if_req = 1'b1; bus.if_addr = 16'h0050; bus.mem_rdata = 16'hDEAD;
        step();
        for (int k = 0; k < 16; k++) begin
            #1;
            if (k == 14) check("t_ready_early", bus.if_ready, 0);
            if (k == 15) begin
                check("t_ready", bus.if_ready, 1);
                check("t_rdata", bus.if_rdata, 0);
            end
            step();
        end
        idle_inputs();
        #1 check("t_err_set", bus.err, 1);
        step(); step(); #1;
        check("t_err_sticky", bus.err, 1);

        // Reset during a data access abandons it.
        do_reset("r2");
        bus.dm_re = 1'b1; bus.dm_addr = 16'h0060;
        step(); #1;
        check("x_mem_re", bus.mem_re, 1);
        step();
        rst = 1'b1; bus.dm_re = 1'b0; bus.mem_valid = 1'b1; bus.mem_rdata = 16'h7777;
        #1;
        check("x_mem_re_rst", bus.mem_re, 0);
        check("x_mem_addr_rst", bus.mem_addr, 0);
        check("x_dm_ready_rst", bus.dm_ready, 0);
        check("x_stall_rst", bus.stall, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("x_no_stale_ready", bus.dm_ready, 0);
            check("x_idle_re", bus.mem_re, 0);
            step();
        end
        idle_inputs();

        // Read and write together: performed as a write, err raised.
        bus.dm_re = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0070; bus.dm_wdata = 16'h5555;
        step(); #1;
        check("c_mem_we", bus.mem_we, 1);
        check("c_mem_re", bus.mem_re, 0);
        check("c_wdata", bus.mem_wdata, 16'h5555);
        check("c_err", bus.err, 1);
        step();
        bus.mem_valid = 1'b1; bus.mem_rdata = 16'h9999;
        #1;
        check("c_dm_ready", bus.dm_ready, 1);
        check("c_dm_rdata", bus.dm_rdata, 0);
        step();
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
